// File: rtl/seq_checker.sv
// Player-turn checker for the colour-sequence game: compares each button press against the ROM.
// Optional press timeout is enabled by defining SEQ_CHECKER_TIMEOUT_EN.
module seq_checker #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] rodada,
  input  logic [3:0] botoes,
  input  logic [3:0] esperado,
  output logic [3:0] address,
  output logic [3:0] cor,
  output logic       ativo,
  output logic       acerto,
  output logic       erro
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMA   = 2'd1,
    ESPERA = 2'd2,
    SOLTA  = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [3:0] address_r, address_s;
  logic [3:0] cor_r, cor_s;
  logic       ativo_r;
  logic       acerto_r, acerto_s;
  logic       erro_r, erro_s;

`ifdef SEQ_CHECKER_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_r, cnt_s;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_s   = state_r;
    address_s = address_r;
    cor_s     = cor_r;
    acerto_s  = 1'b0;
    erro_s    = 1'b0;
`ifdef SEQ_CHECKER_TIMEOUT_EN
    cnt_s     = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        address_s = 4'd0;
        if (start) begin
          state_s = ARMA;
        end else begin
          state_s = IDLE;
        end
      end
      ARMA: begin
        if (botoes == 4'd0) begin
          state_s = ESPERA;
`ifdef SEQ_CHECKER_TIMEOUT_EN
          cnt_s   = '0;
`endif
        end else begin
          state_s = ARMA;
        end
      end
      ESPERA: begin
        if (botoes != 4'd0) begin
          cor_s = botoes;
          // exact match only: several buttons at once is a wrong press
          if (botoes == esperado) begin
            state_s = SOLTA;
          end else begin
            erro_s    = 1'b1;
            state_s   = IDLE;
            address_s = 4'd0;
          end
        end else begin
`ifdef SEQ_CHECKER_TIMEOUT_EN
          if (cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
            erro_s    = 1'b1;
            state_s   = IDLE;
            address_s = 4'd0;
          end else begin
            cnt_s   = cnt_r + CW'(1);
            state_s = ESPERA;
          end
`else
          state_s = ESPERA;
`endif
        end
      end
      SOLTA: begin
        if (botoes == 4'd0) begin
          // >= also stops the index at 15 so it can never wrap
          if (address_r >= rodada) begin
            acerto_s  = 1'b1;
            state_s   = IDLE;
            address_s = 4'd0;
          end else begin
            address_s = address_r + 4'd1;
            state_s   = ESPERA;
`ifdef SEQ_CHECKER_TIMEOUT_EN
            cnt_s     = '0;
`endif
          end
        end else begin
          state_s = SOLTA;
        end
      end
      default: begin
        state_s   = IDLE;
        address_s = 4'd0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      address_r <= 4'd0;
      cor_r     <= 4'd0;
      ativo_r   <= 1'b0;
      acerto_r  <= 1'b0;
      erro_r    <= 1'b0;
`ifdef SEQ_CHECKER_TIMEOUT_EN
      cnt_r     <= '0;
`endif
    end else begin
      state_r   <= state_s;
      address_r <= address_s;
      cor_r     <= cor_s;
      ativo_r   <= (state_s != IDLE);
      acerto_r  <= acerto_s;
      erro_r    <= erro_s;
`ifdef SEQ_CHECKER_TIMEOUT_EN
      cnt_r     <= cnt_s;
`endif
    end
  end

  assign address = address_r;
  assign cor     = cor_r;
  assign ativo   = ativo_r;
  assign acerto  = acerto_r;
  assign erro    = erro_r;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: directed scenarios plus randomized turns against a turn-level model.
module tb_seq_checker;

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] rodada;
  logic [3:0] botoes;
  logic [3:0] esperado;
  logic [3:0] address;
  logic [3:0] cor;
  logic       ativo;
  logic       acerto;
  logic       erro;

  logic [3:0] rom [16];
  logic [3:0] exp_cor;
  int         n_assert;
  int         n_fail;

  assign esperado = rom[address];

  seq_checker #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .start(start), .rodada(rodada),
    .botoes(botoes), .esperado(esperado), .address(address), .cor(cor),
    .ativo(ativo), .acerto(acerto), .erro(erro)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_ativo"}, ativo, 1'b0);
    chk4({tag, "_addr"}, address, 4'd0);
    chk1({tag, "_acerto"}, acerto, 1'b0);
    chk1({tag, "_erro"}, erro, 1'b0);
  endtask

  // Start a turn from IDLE with buttons released; leaves the DUT waiting for the first press.
  task automatic start_turn(input logic [3:0] rnd);
    rodada = rnd;
    botoes = 4'd0;
    start  = 1'b1;
    tick();
    chk1("start_ativo", ativo, 1'b1);
    chk4("start_addr", address, 4'd0);
    start = 1'b0;
    tick();
    chk1("arm_ativo", ativo, 1'b1);
  endtask

  // One press/release of sequence step idx; the model outcome follows from rom[idx] and rnd.
  task automatic press(input logic [3:0] idx, input logic [3:0] p, input logic [3:0] rnd,
                       output logic done);
    int k;
    k = $urandom_range(0, 3);
    for (int c = 0; c < k; c++) begin
      botoes = 4'd0;
      start  = 1'($urandom_range(0, 1));
      tick();
      chk1("wait_ativo", ativo, 1'b1);
      chk1("wait_erro", erro, 1'b0);
    end
    start  = 1'b0;
    botoes = p;
    tick();
    exp_cor = p;
    chk4("press_cor", cor, exp_cor);
    if (p == rom[idx]) begin
      chk1("hit_erro", erro, 1'b0);
      chk1("hit_ativo", ativo, 1'b1);
      chk4("hit_addr", address, idx);
      k = $urandom_range(0, 2);
      for (int c = 0; c < k; c++) begin
        botoes = 4'($urandom_range(1, 15));
        start  = 1'($urandom_range(0, 1));
        tick();
        chk1("hold_ativo", ativo, 1'b1);
        chk4("hold_cor", cor, exp_cor);
      end
      start  = 1'b0;
      botoes = 4'd0;
      tick();
      if (idx == rnd) begin
        chk1("done_acerto", acerto, 1'b1);
        chk1("done_erro", erro, 1'b0);
        chk1("done_ativo", ativo, 1'b0);
        chk4("done_addr", address, 4'd0);
        tick();
        chk1("done_pulse", acerto, 1'b0);
        done = 1'b1;
      end else begin
        chk1("next_acerto", acerto, 1'b0);
        chk4("next_addr", address, idx + 4'd1);
        chk1("next_ativo", ativo, 1'b1);
        done = 1'b0;
      end
    end else begin
      chk1("miss_erro", erro, 1'b1);
      chk1("miss_acerto", acerto, 1'b0);
      chk1("miss_ativo", ativo, 1'b0);
      chk4("miss_addr", address, 4'd0);
      botoes = 4'd0;
      tick();
      chk1("miss_pulse", erro, 1'b0);
      done = 1'b1;
    end
  endtask

  initial begin
    logic       done;
    logic [3:0] rnd;
    logic [3:0] p;
    n_assert = 0;
    n_fail   = 0;
    exp_cor  = 4'd0;
    rodada   = 4'd0;
    for (int j = 0; j < 16; j++) rom[j] = 4'b0001;
    rom[0] = 4'b0001; rom[1] = 4'b0100; rom[2] = 4'b0010; rom[3] = 4'b1000;

    // reset wins over start and buttons
    reset = 1'b1; start = 1'b1; botoes = 4'b0001;
    tick();
    chk_idle("rst");
    chk4("rst_cor", cor, 4'd0);
    reset = 1'b0; start = 1'b0; botoes = 4'd0;
    tick();
    chk_idle("post_rst");

    // button held through start: no compare until released
    rodada = 4'd3; start = 1'b1; botoes = 4'b0001;
    tick();
    chk1("held_ativo", ativo, 1'b1);
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1("held_ativo", ativo, 1'b1);
      chk1("held_erro", erro, 1'b0);
      chk4("held_cor", cor, exp_cor);
      chk4("held_addr", address, 4'd0);
    end
    botoes = 4'd0;
    tick();
    press(4'd0, rom[0], 4'd3, done);
    press(4'd1, rom[1], 4'd3, done);
    chk4("pre_rst_addr", address, 4'd2);

    // mid-turn reset aborts silently
    reset = 1'b1; start = 1'b1; botoes = rom[2];
    tick();
    chk_idle("mid_rst");
    chk4("mid_rst_cor", cor, 4'd0);
    exp_cor = 4'd0;
    reset = 1'b0; start = 1'b0; botoes = 4'd0;
    tick();
    chk_idle("mid_rst_after");

    // full correct turn through index 2
    start_turn(4'd2);
    for (int i = 0; i <= 2; i++) press(4'(i), rom[i], 4'd2, done);
    chk1("turn2_done", done, 1'b1);

    // wrong colour at index 1
    start_turn(4'd3);
    press(4'd0, 4'b0001, 4'd3, done);
    press(4'd1, 4'b1000, 4'd3, done);
    chk4("wrong_cor", cor, 4'b1000);

    // two buttons at once
    start_turn(4'd3);
    press(4'd0, 4'b0101, 4'd3, done);

`ifdef SEQ_CHECKER_TIMEOUT_EN
    start_turn(4'd0);
    for (int c = 0; c < 7; c++) begin
      tick();
      chk1("to_wait_erro", erro, 1'b0);
      chk1("to_wait_ativo", ativo, 1'b1);
    end
    tick();
    chk1("to_erro", erro, 1'b1);
    chk1("to_ativo", ativo, 1'b0);
    tick();
    chk1("to_pulse", erro, 1'b0);
    start_turn(4'd0);
    for (int c = 0; c < 7; c++) tick();
    botoes = rom[0];
    tick();
    chk1("to_late_erro", erro, 1'b0);
    chk1("to_late_ativo", ativo, 1'b1);
    botoes = 4'd0;
    tick();
    chk1("to_late_acerto", acerto, 1'b1);
    tick();
`else
    start_turn(4'd0);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk1("nto_erro", erro, 1'b0);
      chk1("nto_ativo", ativo, 1'b1);
    end
    press(4'd0, rom[0], 4'd0, done);
`endif

    // randomized turns, ROM re-rolled for each
    for (int t = 0; t < 40; t++) begin
      for (int j = 0; j < 16; j++) rom[j] = 4'b0001 << $urandom_range(0, 3);
      rnd = 4'($urandom_range(0, 15));
      start_turn(rnd);
      done = 1'b0;
      for (int i = 0; i < 16 && !done; i++) begin
        if ($urandom_range(0, 11) == 0) begin
          do p = 4'($urandom_range(1, 15)); while (p == rom[i]);
        end else begin
          p = rom[i];
        end
        press(4'(i), p, rnd, done);
      end
      chk1("rand_done", done, 1'b1);
      chk_idle("rand_end");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the player press-timeout length in clock cycles; it is used only when SEQ_CHECKER_TIMEOUT_EN is defined.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a level-high sample begins a player turn.
REQ-005 The block SHALL have port rodada, input, 4 bits: last sequence index to check this turn (0..15).
REQ-006 The block SHALL have port botoes, input, 4 bits: player buttons, active-high, already synchronized; bit order matches the sequence ROM colour encoding.
REQ-007 The block SHALL have port esperado, input, 4 bits: one-hot expected colour, driven combinationally by the sequence ROM from address.
REQ-008 The block SHALL have port address, output, 4 bits: registered index presented to the sequence ROM.
REQ-009 The block SHALL have port cor, output, 4 bits: last captured button pattern, for display.
REQ-010 The block SHALL have port ativo, output, 1 bit: high while a turn is in progress.
REQ-011 The block SHALL have port acerto, output, 1 bit: one-cycle pulse on turn completed correctly.
REQ-012 The block SHALL have port erro, output, 1 bit: one-cycle pulse on a wrong press or a timeout.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, ARMA (wait for all buttons released), ESPERA (wait for a press), SOLTA (wait for release).
REQ-014 In IDLE: ativo=0 and address=0; start=1 SHALL move to ARMA with address=0.
REQ-015 start SHALL be ignored in every state other than IDLE.
REQ-016 In ARMA: botoes==0 SHALL move to ESPERA; otherwise the FSM SHALL stay in ARMA.
REQ-017 In ESPERA with botoes==0: the FSM SHALL stay in ESPERA.
REQ-018 In ESPERA with botoes!=0: cor<=botoes, and the pattern SHALL be compared with esperado in the same cycle.
REQ-019 On an exact 4-bit match the FSM SHALL move to SOLTA; on any mismatch, including multiple buttons pressed, it SHALL pulse erro and move to IDLE.
REQ-020 In SOLTA: changes on botoes SHALL be ignored until botoes==0.
REQ-021 On release in SOLTA with address==rodada: the block SHALL pulse acerto and move to IDLE.
REQ-022 On release in SOLTA with address!=rodada: address SHALL increment by 1 and the FSM SHALL move to ESPERA.
REQ-023 address SHALL NOT wrap: rodada=15 completes at address=15, returning to IDLE with address=0.
REQ-024 acerto and erro SHALL be registered, high for exactly the one cycle after the deciding edge, and never high together.
REQ-025 ativo SHALL be 1 in ARMA, ESPERA and SOLTA, and 0 in IDLE.
REQ-026 rodada SHALL be sampled continuously; the team requires it stable during a turn.
REQ-027 The decision latency from a press or release sample to the next state SHALL be one clock.

Reset
REQ-028 When reset=1 at a rising edge, the block SHALL set state=IDLE, address=0, cor=0, ativo=0, acerto=0, erro=0, and timeout counter=0.
REQ-029 Reset SHALL take priority over start and botoes, and mid-turn reset SHALL abort the turn without any acerto or erro pulse.

Configuration
REQ-030 The macro SEQ_CHECKER_TIMEOUT_EN SHALL control a press-timeout feature.
REQ-031 With SEQ_CHECKER_TIMEOUT_EN defined: a counter SHALL clear on every entry to ESPERA and increment each cycle in ESPERA with botoes==0.
REQ-032 With SEQ_CHECKER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 with no press, the block SHALL pulse erro and go to IDLE; a press on that same cycle SHALL take priority.
REQ-033 With SEQ_CHECKER_TIMEOUT_EN undefined, no counter SHALL exist and ESPERA SHALL wait indefinitely.

Verification
REQ-034 ROM (0->0001, 1->0100, 2->0010, 3->1000), rodada=2, start; press/release 0001, 0100, 0010 -> single acerto pulse, erro=0, address returns to 0, ativo=0.
REQ-035 rodada=3; press 0001, release, press 1000 at address=1 -> erro pulse, cor=1000, IDLE, address=0.
REQ-036 botoes=0001 held during start -> FSM stays in ARMA with no compare; after release, press 0001 -> accepted, address=1.
REQ-037 Press 0101 at address=0 -> erro pulse, no acerto.
REQ-038 reset=1 at address=2 in ESPERA -> next cycle all outputs 0, no pulse; a later start restarts from address=0.
REQ-039 SEQ_CHECKER_TIMEOUT_EN defined with TIMEOUT_CYCLES=8; start with no press -> erro exactly 8 cycles after ESPERA entry; a press on cycle 8 gives a normal compare.
